// File: rtl/ram8_regfile.sv
// 8 x DATA_W register-file RAM: clocked load-enabled write, asynchronous read on a shared address.
// Optional macro RAM8_WRITE_BYPASS_EN forwards the write data to out while load is high.
module ram8_regfile #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_word [Depth];
  logic [DATA_W-1:0] w_rd_data;

  // Write strobe only on load; address/data are don't-care otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        r_word[i] <= '0;
      end
    end else if (load) begin
      r_word[address] <= in;
    end
  end

  assign w_rd_data = r_word[address];

`ifdef RAM8_WRITE_BYPASS_EN
  assign out = (load && !reset) ? in : w_rd_data;
`else
  assign out = w_rd_data;
`endif

endmodule

// File: tb/tb_ram8_regfile.sv
// Self-checking bench for ram8_regfile: array reference model, per-cycle compare,
// directed literal checks and randomized traffic with occasional resets.
module tb_ram8_regfile;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
`ifdef RAM8_WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              load;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;

  logic [DATA_W-1:0] model [8];
  int compared;
  int mismatched;
  bit checking;

  ram8_regfile #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .address(address),
    .in     (in),
    .out    (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] expected_out();
    if (Bypass && load && !reset) return in;
    return model[address];
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] got,
                     input logic [DATA_W-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: out=0x%04h expected=0x%04h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  // Advance one clock: commit what the DUT saw at the edge, then drive the next inputs.
  task automatic step(input bit rst, input bit ld, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    @(posedge clk);
    #1;
    if (!reset && load) model[address] = in;
    reset   = rst;
    load    = ld;
    address = a;
    in      = d;
    if (rst) clear_model();
  endtask

  task automatic lit(input string name, input logic [DATA_W-1:0] exp);
    #1;
    chk(name, out, exp);
  endtask

  always @(negedge clk) begin
    if (checking) chk("cycle", out, expected_out());
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    checking   = 1'b0;
    reset      = 1'b1;
    load       = 1'b0;
    address    = '0;
    in         = '0;
    clear_model();
    repeat (2) @(posedge clk);
    checking = 1'b1;

    // Reset sweep
    step(1'b0, 1'b0, 3'd0, 16'h0000);
    for (int a = 0; a < 8; a++) begin
      address = a[ADDR_W-1:0];
      lit("reset_sweep", 16'h0000);
    end

    // Directed writes
    step(1'b0, 1'b1, 3'd1, 16'h00FF);
    step(1'b0, 1'b1, 3'd2, 16'hF0F0);
    step(1'b0, 1'b1, 3'd4, 16'hAAAA);
    step(1'b0, 1'b0, 3'd1, 16'h0000);
    lit("rd1", 16'h00FF);
    address = 3'd2; lit("rd2", 16'hF0F0);
    address = 3'd4; lit("rd4", 16'hAAAA);
    address = 3'd0; lit("rd0", 16'h0000);
    address = 3'd3; lit("rd3", 16'h0000);
    address = 3'd7; lit("rd7", 16'h0000);

    // load=0 holds
    step(1'b0, 1'b0, 3'd1, 16'h1234);
    repeat (3) step(1'b0, 1'b0, 3'd1, 16'h1234);
    lit("hold1", 16'h00FF);

    // Read during write
    step(1'b0, 1'b1, 3'd4, 16'h0F0F);
    lit("rdw_before", Bypass ? 16'h0F0F : 16'hAAAA);
    step(1'b0, 1'b0, 3'd4, 16'h0000);
    lit("rdw_after", 16'h0F0F);

    // Fill all with 0xFFFF
    for (int a = 0; a < 8; a++) step(1'b0, 1'b1, a[ADDR_W-1:0], 16'hFFFF);
    step(1'b0, 1'b0, 3'd0, 16'h0000);
    for (int a = 0; a < 8; a++) begin
      address = a[ADDR_W-1:0];
      lit("fill", 16'hFFFF);
    end

    // Mid-cycle reset pulse, then reset held with load across an edge
    step(1'b0, 1'b0, 3'd5, 16'h0000);
    #2;
    reset = 1'b1;
    clear_model();
    lit("async_rst", 16'h0000);
    load = 1'b1;
    in   = 16'h5555;
    step(1'b1, 1'b1, 3'd5, 16'h5555);
    step(1'b0, 1'b0, 3'd5, 16'h0000);
    lit("rst_over_load", 16'h0000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(39) == 0), $urandom_range(1),
           ADDR_W'($urandom_range(7)), DATA_W'($urandom));
    end
    step(1'b0, 1'b0, 3'd0, 16'h0000);
    @(posedge clk);
    #1;
    checking = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
